// File: rtl/sad_disp_sched.sv
// Sequencing controller for the SAD adder tree: issues one difference row per
// cycle per disparity, folds tree row sums into per-disparity SADs, keeps the minimum.
module sad_disp_sched #(
    parameter int NODE_NUM   = 8,
    parameter int NODE_WIDTH = 4,
    parameter int ROWS       = 8,
    parameter int MAX_DISP   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              busy,
    output logic                              rd_req,
    output logic [$clog2(MAX_DISP)-1:0]       rd_disp,
    output logic [$clog2(ROWS)-1:0]           rd_row,
    input  logic                              rd_vld,
    output logic [NODE_NUM-1:0]               acc_ena,
    input  logic [NODE_WIDTH:0]               acc_res,
    input  logic                              acc_done,
    output logic [$clog2(MAX_DISP)-1:0]       best_disp,
    output logic [NODE_WIDTH+$clog2(ROWS):0]  best_sad,
    output logic                              res_vld
);

    localparam int SAD_W  = NODE_WIDTH + 1 + $clog2(ROWS);
    localparam int DISP_W = $clog2(MAX_DISP);
    localparam int ROW_W  = $clog2(ROWS);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [DISP_W-1:0] LAST_DISP = DISP_W'(MAX_DISP - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_rd_req;
    logic [DISP_W-1:0]  r_rd_disp;
    logic [ROW_W-1:0]   r_rd_row;
    logic [ROW_W-1:0]   r_row_cnt;
    logic [DISP_W-1:0]  r_cmp_disp;
    logic [SAD_W-1:0]   r_sad_acc;
    logic               r_have_best;
    logic [DISP_W-1:0]  r_best_disp;
    logic [SAD_W-1:0]   r_best_sad;
    logic               r_res_vld;

    logic               w_accept;
    logic               w_collect;
    logic [SAD_W-1:0]   w_sum;
    logic               w_better;

    assign w_accept  = r_rd_req & rd_vld;
    assign w_collect = acc_done & ((r_state == S_ISSUE) | (r_state == S_DRAIN));
    assign w_sum     = r_sad_acc + SAD_W'(acc_res);
    // Strict compare keeps the smaller disparity on ties.
    assign w_better  = ~r_have_best | (w_sum < r_best_sad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_rd_req    <= 1'b0;
            r_rd_disp   <= '0;
            r_rd_row    <= '0;
            r_row_cnt   <= '0;
            r_cmp_disp  <= '0;
            r_sad_acc   <= '0;
            r_have_best <= 1'b0;
            r_best_disp <= '0;
            r_best_sad  <= '0;
            r_res_vld   <= 1'b0;
        end else begin
            r_res_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_ISSUE;
                        r_busy      <= 1'b1;
                        r_rd_req    <= 1'b1;
                        r_rd_disp   <= '0;
                        r_rd_row    <= '0;
                        r_row_cnt   <= '0;
                        r_cmp_disp  <= '0;
                        r_sad_acc   <= '0;
                        r_have_best <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        if (r_rd_row == LAST_ROW) begin
                            r_rd_row <= '0;
                            if (r_rd_disp == LAST_DISP) begin
                                r_rd_req <= 1'b0;
                                r_state  <= S_DRAIN;
                            end else begin
                                r_rd_disp <= r_rd_disp + 1'b1;
                            end
                        end else begin
                            r_rd_row <= r_rd_row + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            // Collect overlaps issue; the tree latency guarantees the final
            // collect lands in DRAIN, after the last accept.
            if (w_collect) begin
                if (r_row_cnt == LAST_ROW) begin
                    if (w_better) begin
                        r_best_sad  <= w_sum;
                        r_best_disp <= r_cmp_disp;
                    end
                    r_have_best <= 1'b1;
                    r_sad_acc   <= '0;
                    r_row_cnt   <= '0;
                    r_cmp_disp  <= r_cmp_disp + 1'b1;
                    if (r_cmp_disp == LAST_DISP) begin
                        r_state   <= S_DONE;
                        r_rd_req  <= 1'b0;
                        r_res_vld <= 1'b1;
                    end
                end else begin
                    r_sad_acc <= w_sum;
                    r_row_cnt <= r_row_cnt + 1'b1;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign rd_req    = r_rd_req;
    assign rd_disp   = r_rd_disp;
    assign rd_row    = r_rd_row;
    assign acc_ena   = {NODE_NUM{w_accept}};
    assign best_disp = r_best_disp;
    assign best_sad  = r_best_sad;
    assign res_vld   = r_res_vld;

endmodule

// File: tb/tb_sad_disp_sched.sv
// Scoreboard bench for sad_disp_sched with a behavioural adder-tree/upstream model
// and a reference minimum-SAD search.
module tb_sad_disp_sched;

    localparam int NODE_NUM   = 8;
    localparam int NODE_WIDTH = 4;
    localparam int ROWS       = 4;
    localparam int MAX_DISP   = 4;
    localparam int LOG2N  = $clog2(NODE_NUM);
    localparam int SAD_W  = NODE_WIDTH + 1 + $clog2(ROWS);
    localparam int DISP_W = $clog2(MAX_DISP);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int N      = MAX_DISP * ROWS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 rd_req;
    logic [DISP_W-1:0]    rd_disp;
    logic [ROW_W-1:0]     rd_row;
    logic                 rd_vld = 1'b0;
    logic [NODE_NUM-1:0]  acc_ena;
    logic [NODE_WIDTH:0]  acc_res;
    logic                 acc_done;
    logic [DISP_W-1:0]    best_disp;
    logic [SAD_W-1:0]     best_sad;
    logic                 res_vld;

    sad_disp_sched #(
        .NODE_NUM  (NODE_NUM),
        .NODE_WIDTH(NODE_WIDTH),
        .ROWS      (ROWS),
        .MAX_DISP  (MAX_DISP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .rd_req   (rd_req),
        .rd_disp  (rd_disp),
        .rd_row   (rd_row),
        .rd_vld   (rd_vld),
        .acc_ena  (acc_ena),
        .acc_res  (acc_res),
        .acc_done (acc_done),
        .best_disp(best_disp),
        .best_sad (best_sad),
        .res_vld  (res_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Row sum the upstream/tree pair produces for (disparity,row).
    logic [NODE_WIDTH:0] vals [MAX_DISP][ROWS];
    logic                force_done = 1'b0;
    logic [NODE_WIDTH:0] force_res = '0;

    logic [LOG2N-1:0]    pv;
    logic [NODE_WIDTH:0] pd [LOG2N];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv[0] <= acc_ena[0];
            pd[0] <= vals[rd_disp][rd_row];
            for (int i = 1; i < LOG2N; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign acc_done = force_done | pv[LOG2N-1];
    assign acc_res  = force_done ? force_res : pd[LOG2N-1];

    typedef struct {
        int d;
        int s;
        int lat;
    } exp_t;
    exp_t q[$];

    int start_cyc = 0;
    int exp_issue = 0;
    int stalls    = 0;
    bit issuing   = 0;
    bit got_res   = 0;
    bit chk_next  = 0;
    bit prev_stall = 0;
    logic [DISP_W-1:0] prev_disp;
    logic [ROW_W-1:0]  prev_row;

    always @(negedge clk) begin
        bit   exp_req;
        exp_t e;
        int   lat_exp;
        if (!rst_n) begin
            prev_stall = 0;
            chk_next   = 0;
        end else begin
            exp_req = issuing && (exp_issue < N);
            if (chk_next) begin
                chk("res_vld_one_cycle", res_vld, 1'b0);
                chk("busy_falls", busy, 1'b0);
                chk_next = 0;
            end
            chk("rd_req", rd_req, exp_req);
            chk("acc_ena", acc_ena, (exp_req && rd_vld) ? {NODE_NUM{1'b1}} : '0);
            if (prev_stall) begin
                chk("stall_disp", rd_disp, prev_disp);
                chk("stall_row", rd_row, prev_row);
            end
            if (exp_req && rd_vld) begin
                chk("issue_disp", rd_disp, exp_issue / ROWS);
                chk("issue_row", rd_row, exp_issue % ROWS);
                exp_issue++;
            end
            if (exp_req && !rd_vld) stalls++;
            prev_stall = exp_req && !rd_vld;
            prev_disp  = rd_disp;
            prev_row   = rd_row;
            if (res_vld) begin
                if (q.size() == 0) begin
                    chk("unexpected_res_vld", res_vld, 1'b0);
                end else begin
                    e = q.pop_front();
                    lat_exp = (e.lat > 0) ? e.lat : (N + LOG2N + 1 + stalls);
                    chk("best_disp", best_disp, e.d);
                    chk("best_sad", best_sad, e.s);
                    chk("latency", cyc - start_cyc, lat_exp);
                end
                got_res  = 1;
                chk_next = 1;
            end
        end
    end

    task automatic set_abs(input int c);
        for (int d = 0; d < MAX_DISP; d++)
            for (int r = 0; r < ROWS; r++)
                vals[d][r] = (NODE_WIDTH+1)'(NODE_NUM * ((d > c) ? d - c : c - d));
    endtask

    task automatic set_const(input int v);
        for (int d = 0; d < MAX_DISP; d++)
            for (int r = 0; r < ROWS; r++)
                vals[d][r] = (NODE_WIDTH+1)'(v);
    endtask

    task automatic set_rand();
        for (int d = 0; d < MAX_DISP; d++)
            for (int r = 0; r < ROWS; r++)
                vals[d][r] = (NODE_WIDTH+1)'($urandom_range(0, 2**(NODE_WIDTH+1) - 1));
    endtask

    // mode 0: rd_vld=1, 1: alternating from 1, 2: random. lat 0 = derive from stalls.
    task automatic run_window(input int mode, input int lat, input int start_at);
        exp_t e;
        int   sad;
        e.d = 0;
        e.s = 0;
        e.lat = lat;
        for (int d = 0; d < MAX_DISP; d++) begin
            sad = 0;
            for (int r = 0; r < ROWS; r++) sad += int'(vals[d][r]);
            if (d == 0 || sad < e.s) begin
                e.s = sad;
                e.d = d;
            end
        end
        q.push_back(e);
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        exp_issue = 0;
        stalls    = 0;
        got_res   = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            issuing = 1'b1;
            case (mode)
                0:       rd_vld = 1'b1;
                1:       rd_vld = (i % 2 == 0);
                default: rd_vld = ($urandom_range(0, 3) != 0);
            endcase
            if (i == start_at) start = 1'b1;
            @(negedge clk); #1;
            if (got_res) break;
        end
        issuing = 1'b0;
        if (!got_res) begin
            chk("timeout", got_res, 1'b1);
            q.delete();
        end
        if (start) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        exp_issue = 0;
        stalls    = 0;
        @(posedge clk); #1;
        start   = 1'b0;
        rd_vld  = 1'b1;
        issuing = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_acc_ena", acc_ena, '0);
        chk("rst_res_vld", res_vld, 1'b0);
        chk("rst_best_disp", best_disp, 0);
        chk("rst_best_sad", best_sad, 0);
        issuing = 1'b0;
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        set_const(0);
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 1'b0);
        chk("init_rd_req", rd_req, 1'b0);
        chk("init_rd_disp", rd_disp, 0);
        chk("init_rd_row", rd_row, 0);
        chk("init_res_vld", res_vld, 1'b0);
        chk("init_best_disp", best_disp, 0);
        chk("init_best_sad", best_sad, 0);
        rst_n = 1'b1;

        set_abs(2);         run_window(0, 20, -1);
        set_const(NODE_NUM); run_window(0, 20, -1);
        set_abs(2);         run_window(1, 35, -1);
        set_rand();         run_window(0, 20, 5);
        set_rand();         run_window(0, 20, 19);

        @(posedge clk); #1;
        force_done = 1'b1;
        force_res  = '1;
        repeat (4) @(posedge clk);
        #1;
        force_done = 1'b0;
        @(negedge clk); #1;
        chk("idle_busy", busy, 1'b0);

        set_rand();  run_window(0, 20, -1);
        set_abs(3);  run_window(0, 20, -1);

        reset_mid();
        set_abs(1);  run_window(0, 20, -1);

        repeat (20) begin
            set_rand();
            run_window(2, 0, -1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
